// File: rtl/dfu_status_led.sv
// Status-LED pattern generator for the TinyDFU bootloader: maps DFU state/detach
// to breathing, blinking or solid PWM patterns for the SB_RGBA_DRV channels.
module dfu_status_led #(
  parameter int unsigned PRESCALE = 23438,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
  output logic       stat_r,
  output logic       stat_g,
  output logic       stat_b,
  output logic       stat_en
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_DNLOAD,
    MODE_MANIFEST,
    MODE_UPLOAD,
    MODE_ERROR,
    MODE_OFF
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS:0]   phase;
  logic [PWM_BITS:0]   step;
  logic                tick;
  logic                breath;
  logic                r_d, g_d, b_d;

  // Detach wins over any state code; undefined codes fall through to error.
  always_comb begin
    mode_d = MODE_ERROR;
    if (dfu_detach)             mode_d = MODE_OFF;
    else if (dfu_state <= 8'd2) mode_d = MODE_IDLE;
    else if (dfu_state <= 8'd5) mode_d = MODE_DNLOAD;
    else if (dfu_state <= 8'd8) mode_d = MODE_MANIFEST;
    else if (dfu_state == 8'd9) mode_d = MODE_UPLOAD;
  end

  always_comb begin
    tick   = (pre_cnt == PRE_W'(PRESCALE - 1));
    step   = (mode_q == MODE_DNLOAD) ? (PWM_BITS+1)'(4) : (PWM_BITS+1)'(1);
    level  = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
    breath = (pwm_cnt < level);
    r_d = 1'b0;
    g_d = 1'b0;
    b_d = 1'b0;
    case (mode_q)
      MODE_IDLE:     begin r_d = breath; b_d = breath; end
      MODE_DNLOAD:   b_d = breath;
      MODE_MANIFEST: g_d = 1'b1;
      MODE_UPLOAD:   begin g_d = breath; b_d = breath; end
      MODE_ERROR:    r_d = ~phase[PWM_BITS];
      default:       ;
    endcase
  end

  // A mode change restarts every counter on the same edge, swallowing any tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      pre_cnt <= '0;
      pwm_cnt <= '0;
      phase   <= '0;
    end else if (mode_d != mode_q) begin
      mode_q  <= mode_d;
      pre_cnt <= '0;
      pwm_cnt <= '0;
      phase   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (tick) phase <= phase + step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r  <= 1'b0;
      stat_g  <= 1'b0;
      stat_b  <= 1'b0;
      stat_en <= 1'b0;
    end else begin
      stat_r  <= r_d;
      stat_g  <= g_d;
      stat_b  <= b_d;
      stat_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dfu_status_led.sv
// Directed bench for dfu_status_led: two instances (PRESCALE 1 and 3) driven in
// parallel and compared every cycle against a small pattern model.
module tb_dfu_status_led;

  localparam int M_IDLE = 0, M_DNLOAD = 1, M_MANIFEST = 2, M_UPLOAD = 3, M_ERROR = 4, M_OFF = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dfu_state = 8'd2;
  logic       dfu_detach = 1'b0;
  logic       r1, g1, b1, en1;
  logic       r3, g3, b3, en3;

  int checks = 0;
  int passed = 0;
  int nsr = 0;
  int cur_mode = M_IDLE;

  always #5 clk = ~clk;

  dfu_status_led #(.PRESCALE(1), .PWM_BITS(8)) u_fast (
    .clk(clk), .rst_n(rst_n), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
    .stat_r(r1), .stat_g(g1), .stat_b(b1), .stat_en(en1)
  );

  dfu_status_led #(.PRESCALE(3), .PWM_BITS(8)) u_slow (
    .clk(clk), .rst_n(rst_n), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
    .stat_r(r3), .stat_g(g3), .stat_b(b3), .stat_en(en3)
  );

  // Expected {r,g,b,en} after n edges since a restart had counters at zero.
  function automatic logic [3:0] model(input int m, input int n, input int ps);
    int   ph, pwm, lvl, stp;
    logic br, blink;
    stp   = (m == M_DNLOAD) ? 4 : 1;
    ph    = ((n / ps) * stp) % 512;
    pwm   = n % 256;
    lvl   = (ph >= 256) ? (511 - ph) : ph;
    br    = (pwm < lvl);
    blink = (ph < 256);
    case (m)
      M_IDLE:     return {br, 1'b0, br, 1'b1};
      M_DNLOAD:   return {1'b0, 1'b0, br, 1'b1};
      M_MANIFEST: return {1'b0, 1'b1, 1'b0, 1'b1};
      M_UPLOAD:   return {1'b0, br, br, 1'b1};
      M_ERROR:    return {blink, 1'b0, 1'b0, 1'b1};
      default:    return 4'b0001;
    endcase
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
    nsr++;
  endtask

  // Edge where a new mode is sampled: outputs still show the old pattern.
  task automatic clk_restart(input int new_mode, input string name);
    logic [3:0] e1, e3;
    e1 = model(cur_mode, nsr, 1);
    e3 = model(cur_mode, nsr, 3);
    @(posedge clk);
    #1;
    checks++;
    if ({r1, g1, b1, en1} !== e1) $display("FAIL %s_latency_fast got=%b exp=%b", name, {r1, g1, b1, en1}, e1);
    else passed++;
    checks++;
    if ({r3, g3, b3, en3} !== e3) $display("FAIL %s_latency_slow got=%b exp=%b", name, {r3, g3, b3, en3}, e3);
    else passed++;
    cur_mode = new_mode;
    nsr = 0;
  endtask

  task automatic test_reset();
    dfu_state  = 8'd2;
    dfu_detach = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r1, g1, b1, en1} !== 4'b0000) $display("FAIL reset_hold_fast got=%b exp=0000", {r1, g1, b1, en1});
    else passed++;
    checks++;
    if ({r3, g3, b3, en3} !== 4'b0000) $display("FAIL reset_hold_slow got=%b exp=0000", {r3, g3, b3, en3});
    else passed++;
    @(negedge clk);
    rst_n    = 1'b1;
    nsr      = 0;
    cur_mode = M_IDLE;
    tick_clk();
    checks++;
    if ({r1, g1, b1, en1} !== 4'b0001) $display("FAIL reset_release_fast got=%b exp=0001", {r1, g1, b1, en1});
    else passed++;
    checks++;
    if ({r3, g3, b3, en3} !== 4'b0001) $display("FAIL reset_release_slow got=%b exp=0001", {r3, g3, b3, en3});
    else passed++;
  endtask

  task automatic test_idle_breath();
    int duty = 0;
    logic [3:0] e1, e3;
    for (int i = 0; i < 600; i++) begin
      tick_clk();
      e1 = model(M_IDLE, nsr - 1, 1);
      e3 = model(M_IDLE, nsr - 1, 3);
      checks++;
      if ({r1, g1, b1, en1} !== e1) $display("FAIL idle_fast n=%0d got=%b exp=%b", nsr - 1, {r1, g1, b1, en1}, e1);
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== e3) $display("FAIL idle_slow n=%0d got=%b exp=%b", nsr - 1, {r3, g3, b3, en3}, e3);
      else passed++;
      if (nsr - 1 >= 256 && nsr - 1 < 512 && r1) duty++;
    end
    checks++;
    if (duty !== 128) $display("FAIL idle_frame_duty got=%0d exp=128", duty);
    else passed++;
  endtask

  task automatic test_download_fast();
    logic [3:0] e1, e3;
    for (int i = 0; i < 600 && (nsr % 512) != 200; i++) tick_clk();
    checks++;
    if ((nsr % 512) != 200) $display("FAIL dnload_align got=%0d exp=200", nsr % 512);
    else passed++;
    dfu_state = 8'd4;
    clk_restart(M_DNLOAD, "dnload");
    for (int i = 0; i < 300; i++) begin
      tick_clk();
      e1 = model(M_DNLOAD, nsr - 1, 1);
      e3 = model(M_DNLOAD, nsr - 1, 3);
      checks++;
      if ({r1, g1, b1, en1} !== e1) $display("FAIL dnload_fast n=%0d got=%b exp=%b", nsr - 1, {r1, g1, b1, en1}, e1);
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== e3) $display("FAIL dnload_slow n=%0d got=%b exp=%b", nsr - 1, {r3, g3, b3, en3}, e3);
      else passed++;
      if (i == 100) dfu_state = 8'd3;
    end
  endtask

  task automatic test_error();
    int highs = 0;
    logic [3:0] e1, e3;
    dfu_state = 8'd10;
    clk_restart(M_ERROR, "error");
    for (int i = 0; i < 600; i++) begin
      tick_clk();
      e1 = model(M_ERROR, nsr - 1, 1);
      e3 = model(M_ERROR, nsr - 1, 3);
      checks++;
      if ({r1, g1, b1, en1} !== e1) $display("FAIL error_fast n=%0d got=%b exp=%b", nsr - 1, {r1, g1, b1, en1}, e1);
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== e3) $display("FAIL error_slow n=%0d got=%b exp=%b", nsr - 1, {r3, g3, b3, en3}, e3);
      else passed++;
      if (nsr - 1 < 512 && r1) highs++;
      if (i == 100) dfu_state = 8'hFF;
    end
    checks++;
    if (highs !== 256) $display("FAIL error_blink_high got=%0d exp=256", highs);
    else passed++;
  endtask

  task automatic test_manifest_detach();
    dfu_state = 8'd7;
    clk_restart(M_MANIFEST, "manifest");
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      checks++;
      if ({r1, g1, b1, en1} !== 4'b0101) $display("FAIL manifest_fast got=%b exp=0101", {r1, g1, b1, en1});
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== 4'b0101) $display("FAIL manifest_slow got=%b exp=0101", {r3, g3, b3, en3});
      else passed++;
    end
    dfu_detach = 1'b1;
    clk_restart(M_OFF, "detach");
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      checks++;
      if ({r1, g1, b1, en1} !== 4'b0001) $display("FAIL detach_fast got=%b exp=0001", {r1, g1, b1, en1});
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== 4'b0001) $display("FAIL detach_slow got=%b exp=0001", {r3, g3, b3, en3});
      else passed++;
    end
    dfu_detach = 1'b0;
    clk_restart(M_MANIFEST, "reattach");
    tick_clk();
    checks++;
    if ({r1, g1, b1, en1} !== 4'b0101) $display("FAIL reattach_fast got=%b exp=0101", {r1, g1, b1, en1});
    else passed++;
    checks++;
    if ({r3, g3, b3, en3} !== 4'b0101) $display("FAIL reattach_slow got=%b exp=0101", {r3, g3, b3, en3});
    else passed++;
  endtask

  task automatic test_upload();
    logic [3:0] e1;
    dfu_state = 8'd9;
    clk_restart(M_UPLOAD, "upload");
    for (int i = 0; i < 400; i++) begin
      tick_clk();
      e1 = model(M_UPLOAD, nsr - 1, 1);
      checks++;
      if ({r1, g1, b1, en1} !== e1) $display("FAIL upload_fast n=%0d got=%b exp=%b", nsr - 1, {r1, g1, b1, en1}, e1);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic found = 1'b0;
    logic [3:0] e1, e3;
    dfu_state = 8'd1;
    clk_restart(M_IDLE, "async_pre");
    for (int i = 0; i < 600 && !found; i++) begin
      tick_clk();
      if (nsr - 1 >= 256 && r1) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL async_find_high got=0 exp=1");
    else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r1, g1, b1, en1} !== 4'b0000) $display("FAIL async_reset_fast got=%b exp=0000", {r1, g1, b1, en1});
    else passed++;
    checks++;
    if ({r3, g3, b3, en3} !== 4'b0000) $display("FAIL async_reset_slow got=%b exp=0000", {r3, g3, b3, en3});
    else passed++;
    #2;
    rst_n    = 1'b1;
    nsr      = 0;
    cur_mode = M_IDLE;
    for (int i = 0; i < 300; i++) begin
      tick_clk();
      e1 = model(M_IDLE, nsr - 1, 1);
      e3 = model(M_IDLE, nsr - 1, 3);
      checks++;
      if ({r1, g1, b1, en1} !== e1) $display("FAIL restart_fast n=%0d got=%b exp=%b", nsr - 1, {r1, g1, b1, en1}, e1);
      else passed++;
      checks++;
      if ({r3, g3, b3, en3} !== e3) $display("FAIL restart_slow n=%0d got=%b exp=%b", nsr - 1, {r3, g3, b3, en3}, e3);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_breath();
    test_download_fast();
    test_error();
    test_manifest_detach();
    test_upload();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
